// File: rtl/p_hardisc.sv
// Shared executor package: function encodings and clmu state type.
// Holds the carry-less multiply result selection helpers.
package p_hardisc;

    typedef logic [3:0] f_part;

    localparam f_part BEU_CLMUL  = 4'd10;
    localparam f_part BEU_CLMULH = 4'd11;
    localparam f_part BEU_CLMULR = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } clmu_state_t;

    function automatic logic clmu_supported(f_part f);
        return (f == BEU_CLMUL) | (f == BEU_CLMULH) | (f == BEU_CLMULR);
    endfunction

    function automatic logic [31:0] clmu_sel(f_part f, logic [63:0] p);
        logic [31:0] r;
        r = '0;
        unique case (1'b1)
            (f == BEU_CLMUL):  r = p[31:0];
            (f == BEU_CLMULH): r = p[63:32];
            (f == BEU_CLMULR): r = p[62:31];
            default:           r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/clmu_step.sv
// One carry-less partial-product step: xor mcand into acc when bit_en.
// Ports: acc, mcand (64b), bit_en (1b) in; nxt (64b) out.
module clmu_step (
    input  logic [63:0] acc,
    input  logic [63:0] mcand,
    input  logic        bit_en,
    output logic [63:0] nxt
);

    assign nxt = bit_en ? (acc ^ mcand) : acc;

endmodule

// File: rtl/clmu.sv
// Multi-cycle carry-less multiplier for CLMUL/CLMULH/CLMULR.
// Ports: clk, async active-low reset, start/function/op1/op2, flush,
// ack in; ready, valid, registered 32b result out.
// Macro CLMU_RADIX4_EN: retire two multiplier bits per BUSY cycle.
module clmu
    import p_hardisc::*;
(
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_start_i,
    input  f_part       s_function_i,
    input  logic [31:0] s_op1_i,
    input  logic [31:0] s_op2_i,
    input  logic        s_flush_i,
    input  logic        s_ack_i,
    output logic        s_ready_o,
    output logic        s_valid_o,
    output logic [31:0] s_result_o
);

    clmu_state_t state, state_nxt;
    logic [63:0] mcand, mcand_nxt, mcand_sh;
    logic [63:0] acc, acc_nxt, acc_step;
    logic [31:0] mult, mult_nxt, mult_sh;
    logic [31:0] result, result_nxt;
    f_part       func, func_nxt;
    logic        load;

`ifdef CLMU_RADIX4_EN
    logic [63:0] acc_mid;

    clmu_step u_step0 (
        .acc    (acc),
        .mcand  (mcand),
        .bit_en (mult[0]),
        .nxt    (acc_mid)
    );

    clmu_step u_step1 (
        .acc    (acc_mid),
        .mcand  ({mcand[62:0], 1'b0}),
        .bit_en (mult[1]),
        .nxt    (acc_step)
    );

    assign mcand_sh = {mcand[61:0], 2'b0};
    assign mult_sh  = {2'b0, mult[31:2]};
`else
    clmu_step u_step0 (
        .acc    (acc),
        .mcand  (mcand),
        .bit_en (mult[0]),
        .nxt    (acc_step)
    );

    assign mcand_sh = {mcand[62:0], 1'b0};
    assign mult_sh  = {1'b0, mult[31:1]};
`endif

    // DONE accepts a new request only in the ack cycle (back-to-back).
    assign s_ready_o  = (state == IDLE) | ((state == DONE) & s_ack_i);
    assign s_valid_o  = (state == DONE);
    assign s_result_o = result;
    assign load       = s_ready_o & s_start_i & ~s_flush_i;

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mult_nxt   = mult;
        acc_nxt    = acc;
        func_nxt   = func;
        result_nxt = result;
        if (s_flush_i) begin
            state_nxt = IDLE;
        end else if (load) begin
            mcand_nxt = {32'b0, s_op1_i};
            mult_nxt  = s_op2_i;
            acc_nxt   = '0;
            func_nxt  = s_function_i;
            // Nothing to accumulate: the answer is known to be zero.
            if ((s_op2_i == '0) | ~clmu_supported(s_function_i)) begin
                state_nxt  = DONE;
                result_nxt = '0;
            end else begin
                state_nxt = BUSY;
            end
        end else begin
            unique case (state)
                BUSY: begin
                    acc_nxt   = acc_step;
                    mcand_nxt = mcand_sh;
                    mult_nxt  = mult_sh;
                    if (mult_sh == '0) begin
                        state_nxt  = DONE;
                        result_nxt = clmu_sel(func, acc_step);
                    end
                end
                DONE: begin
                    if (s_ack_i)
                        state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state  <= IDLE;
            mcand  <= '0;
            mult   <= '0;
            acc    <= '0;
            func   <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mult   <= mult_nxt;
            acc    <= acc_nxt;
            func   <= func_nxt;
            result <= result_nxt;
        end
    end

endmodule

// File: tb/tb_clmu.sv
// Self-checking bench for clmu: vector table, scoreboard queue and
// hand-written flush / back-to-back / reset sequences.
module tb_clmu;
    import p_hardisc::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        ack = 1'b0;
    f_part       func = BEU_CLMUL;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        ready;
    logic        valid;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic [31:0] last_exp;

    typedef struct {
        f_part       f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    clmu dut (
        .s_clk_i      (clk),
        .s_resetn_i   (rst_n),
        .s_start_i    (start),
        .s_function_i (func),
        .s_op1_i      (op1),
        .s_op2_i      (op2),
        .s_flush_i    (flush),
        .s_ack_i      (ack),
        .s_ready_o    (ready),
        .s_valid_o    (valid),
        .s_result_o   (result)
    );

    function automatic logic [31:0] ref_res(f_part f, logic [31:0] a,
                                            logic [31:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++)
            if (b[i]) p = p ^ ({32'b0, a} << i);
        if (f == BEU_CLMUL)  return p[31:0];
        if (f == BEU_CLMULH) return p[63:32];
        if (f == BEU_CLMULR) return p[62:31];
        return 32'h0;
    endfunction

    function automatic int exp_lat(f_part f, logic [31:0] b);
        int m;
        m = 0;
        if (b == 0) return 1;
        if (f != BEU_CLMUL && f != BEU_CLMULH && f != BEU_CLMULR) return 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) m = i;
`ifdef CLMU_RADIX4_EN
        return m / 2 + 2;
`else
        return m + 2;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic start_op(f_part f, logic [31:0] a, logic [31:0] b,
                            logic [31:0] exp);
        func  = f;
        op1   = a;
        op2   = b;
        start = 1'b1;
        sb.push_back(exp);
    endtask

    // Start is high in the current cycle; count edges until valid.
    task automatic wait_valid(string name, int lat);
        int n;
        n = 1;
        @(posedge clk); #1;
        start = 1'b0;
        ack   = 1'b0;
        while (!valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, n, lat);
        if (sb.size() == 0) begin
            chk({name, " scoreboard"}, 0, 1);
            last_exp = 'x;
        end else begin
            last_exp = sb.pop_front();
            chk({name, " result"}, result, last_exp);
        end
    endtask

    task automatic hold_ack(string name);
        repeat (2) begin
            @(posedge clk); #1;
            chk({name, " hold valid"}, valid, 1);
            chk({name, " hold result"}, result, last_exp);
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk({name, " valid drop"}, valid, 0);
        chk({name, " ready idle"}, ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        f_part fr;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{BEU_CLMUL,  32'h3,        32'h3,        32'h5};
        vecs[1] = '{BEU_CLMUL,  32'h80000000, 32'h80000000, 32'h0};
        vecs[2] = '{BEU_CLMULH, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[3] = '{BEU_CLMULR, 32'h80000000, 32'h80000000, 32'h80000000};
        vecs[4] = '{BEU_CLMUL,  32'hFFFFFFFF, 32'h0,        32'h0};
        vecs[5] = '{4'h0,       32'h3,        32'h3,        32'h0};
        vecs[6] = '{BEU_CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555};
        vecs[7] = '{BEU_CLMULR, 32'hFFFFFFFF, 32'h1,        32'h1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", ready, 1);
        chk("reset valid", valid, 0);
        chk("reset result", result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_valid($sformatf("vec%0d", i),
                       exp_lat(vecs[i].f, vecs[i].b));
            hold_ack($sformatf("vec%0d", i));
        end

        // Back-to-back: ack and next start in the same DONE cycle.
        start_op(BEU_CLMUL, 32'h5, 32'h7, 32'h1B);
        wait_valid("b2b first", exp_lat(BEU_CLMUL, 32'h7));
        ack = 1'b1;
        start_op(BEU_CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555);
        #1;
        chk("b2b ready", ready, 1);
        wait_valid("b2b second", exp_lat(BEU_CLMULH, 32'hFFFFFFFF));
        hold_ack("b2b second");

        // Start while BUSY is ignored.
        start_op(BEU_CLMULR, 32'h80000000, 32'h80000000, 32'h80000000);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        func  = BEU_CLMUL;
        op1   = 32'hFFFFFFFF;
        op2   = 32'h0;
        start = 1'b1;
        #1;
        chk("busy ready", ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy start ignored", valid, 0);
        n = 0;
        while (!valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy done", valid, 1);
        last_exp = sb.pop_front();
        chk("busy result", result, last_exp);
        hold_ack("busy");

        // Flush at cycle 5 of a long request.
        func  = BEU_CLMUL;
        op1   = 32'h12345678;
        op2   = 32'h80000000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("flush busy ready", ready, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush ready", ready, 1);
        chk("flush result kept", result, last_exp);
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) n++;
        end
        chk("flush no valid", n, 0);
        start_op(BEU_CLMUL, 32'h5, 32'h7, 32'h1B);
        wait_valid("after flush", exp_lat(BEU_CLMUL, 32'h7));
        hold_ack("after flush");

        // Flush together with start in IDLE.
        func  = BEU_CLMUL;
        op1   = 32'h3;
        op2   = 32'h0;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        n = 0;
        repeat (5) begin
            if (valid) n++;
            @(posedge clk); #1;
        end
        chk("flush+start no op", n, 0);
        chk("flush+start ready", ready, 1);

        // Random regression against the software model.
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0: fr = BEU_CLMUL;
                1: fr = BEU_CLMULH;
                default: fr = BEU_CLMULR;
            endcase
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            start_op(fr, a, b, ref_res(fr, a, b));
            wait_valid($sformatf("rand%0d", i), exp_lat(fr, b));
            ack = 1'b1;
            @(posedge clk); #1;
            ack = 1'b0;
        end

        // Async reset mid-BUSY with a nonzero result register.
        start_op(BEU_CLMUL, 32'h5, 32'h7, 32'h1B);
        wait_valid("pre reset", exp_lat(BEU_CLMUL, 32'h7));
        ack = 1'b1;
        @(posedge clk); #1;
        ack   = 1'b0;
        func  = BEU_CLMUL;
        op1   = 32'hFFFFFFFF;
        op2   = 32'h80000000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async ready", ready, 1);
        chk("async valid", valid, 0);
        chk("async result", result, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(BEU_CLMUL, 32'h3, 32'h3, 32'h5);
        wait_valid("post reset", exp_lat(BEU_CLMUL, 32'h3));
        hold_ack("post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
